// File: rtl/calc_pkg.sv
// Shared calculator types and constants: operation codes, sequencer states, fixed-point scale.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

   // Operation code as issued by the keypad/state controller
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_MUL = 2'd2,
      ALU_DIV = 2'd3
   } alu_op_t;

   // Sequencer control states
   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_MUL    = 2'd1,
      SEQ_DIV    = 2'd2,
      SEQ_FINISH = 2'd3
   } seq_state_t;

   // Integer power of ten, evaluated at elaboration time
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] v;
      v = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         v = v * 64'd10;
      end
      return v;
   endfunction

   // Number of decimal fraction digits carried by every operand and result
   localparam int unsigned FRAC_DIGITS = 2;
   localparam logic [63:0] SCALE       = pow10(FRAC_DIGITS);

   localparam logic [63:0] S64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] S64_MIN = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the calculator controller and the arithmetic sequencer.
// Latency: n/a (wiring only).
// Backpressure: start is honoured only while busy is low; there is no other flow control.
interface alu_sequencer_if;

   logic        start;
   logic        clear;
   logic [1:0]  op;
   logic [63:0] operand_a;
   logic [63:0] operand_b;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        overflow;
   logic        div_zero;

   // Controller side
   modport master (
      output start, clear, op, operand_a, operand_b,
      input  busy, done, result, overflow, div_zero
   );

   // Sequencer side
   modport slave (
      input  start, clear, op, operand_a, operand_b,
      output busy, done, result, overflow, div_zero
   );

endinterface

// File: rtl/seq_divider.sv
// 128/64 unsigned restoring divider, one quotient bit per step, load/step/quotient control.
// Latency: quotient valid after exactly 128 step cycles following a load.
// Backpressure: none; the caller owns sequencing and must not step past 128.
module seq_divider (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [127:0] i_dividend,
   input  logic [63:0]  i_divisor,
   input  logic         i_step,
   output logic [127:0] o_quotient
);

   logic [127:0] r_q;     // dividend shifts out the top, quotient bits shift in at the bottom
   logic [63:0]  r_rem;   // partial remainder, always below the divisor
   logic [63:0]  r_dsr;
   logic [64:0]  w_trial;
   logic [64:0]  w_diff;
   logic         w_ge;

   assign w_trial = {r_rem, r_q[127]};
   assign w_diff  = w_trial - {1'b0, r_dsr};
   // trial < 2*divisor, so a non-negative difference never sets bit 64
   assign w_ge    = ~w_diff[64];

   // Load operands, then restore-or-subtract one bit per step
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q   <= '0;
         r_rem <= '0;
         r_dsr <= '0;
      end else if (i_load) begin
         r_q   <= i_dividend;
         r_rem <= '0;
         r_dsr <= i_divisor;
      end else if (i_step) begin
         r_q   <= {r_q[126:0], w_ge};
         r_rem <= w_ge ? w_diff[63:0] : w_trial[63:0];
      end
   end

   assign o_quotient = r_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle signed fixed-point add/sub/mul/div; ALU_SATURATE_EN selects clamping on overflow.
// Latency: add/sub/div-by-zero 1 cycle, div 129 cycles, mul 193 cycles after start is sampled.
// Backpressure: start ignored while busy; clear aborts to idle with no done pulse.
module alu_sequencer
   import calc_pkg::*;
(
   input  logic           clock,
   input  logic           reset_n,
   alu_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE   = SEQ_IDLE;
   localparam logic [1:0] S_MUL    = SEQ_MUL;
   localparam logic [1:0] S_DIV    = SEQ_DIV;
   localparam logic [1:0] S_FINISH = SEQ_FINISH;

   localparam logic [127:0] SCALE_W = {64'd0, SCALE};

   logic [1:0]   r_state;
   logic [1:0]   r_op;
   logic         r_neg;        // result sign for mul/div
   logic         r_dz;         // divide by zero detected at accept
   logic [63:0]  r_a;
   logic [63:0]  r_b;
   logic [127:0] r_mcand;      // |a| shifted left once per multiply step
   logic [63:0]  r_mplier;     // |b| shifted right once per multiply step
   logic [127:0] r_prod;
   logic [6:0]   r_cnt;
   logic         r_done;
   logic [63:0]  r_result;
   logic         r_ovf;
   logic         r_dz_out;

   logic         w_accept;
   logic [63:0]  w_mag_a;
   logic [63:0]  w_mag_b;
   logic [127:0] w_scaled_a;
   logic [127:0] w_prod_next;
   logic         w_mul_last;
   logic         w_div_last;
   logic         w_div_load;
   logic [127:0] w_div_dvd;
   logic [63:0]  w_div_dsr;
   logic         w_div_step;
   logic [127:0] w_quot;
   logic [64:0]  w_sum;
   logic         w_q_hi_nz;
   logic [63:0]  w_res;
   logic         w_ovf;

   assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.clear;
   assign w_mag_a     = bus.operand_a[63] ? (~bus.operand_a + 64'd1) : bus.operand_a;
   assign w_mag_b     = bus.operand_b[63] ? (~bus.operand_b + 64'd1) : bus.operand_b;
   assign w_scaled_a  = {64'd0, w_mag_a} * SCALE_W;
   assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 128'd0);
   assign w_mul_last  = (r_state == S_MUL) && (r_cnt == 7'd63);
   assign w_div_last  = (r_state == S_DIV) && (r_cnt == 7'd127);

   // The divider is shared: |a|*SCALE / |b| for divide, product / SCALE after multiply.
   // The final multiply step hands its combinational sum straight to the divider.
   assign w_div_load = (w_accept && (bus.op == ALU_DIV) && (bus.operand_b != 64'd0)) || w_mul_last;
   assign w_div_dvd  = (r_state == S_MUL) ? w_prod_next : w_scaled_a;
   assign w_div_dsr  = (r_state == S_MUL) ? SCALE : w_mag_b;
   assign w_div_step = (r_state == S_DIV);

   seq_divider u_div (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_load     (w_div_load),
      .i_dividend (w_div_dvd),
      .i_divisor  (w_div_dsr),
      .i_step     (w_div_step),
      .o_quotient (w_quot)
   );

   // Control FSM plus operand capture and the shift-add multiply loop
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_op     <= 2'd0;
         r_neg    <= 1'b0;
         r_dz     <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (bus.clear) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op     <= bus.op;
                  r_neg    <= bus.operand_a[63] ^ bus.operand_b[63];
                  r_dz     <= (bus.op == ALU_DIV) && (bus.operand_b == 64'd0);
                  r_a      <= bus.operand_a;
                  r_b      <= bus.operand_b;
                  r_mcand  <= {64'd0, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  if (bus.op == ALU_MUL)
                     r_state <= S_MUL;
                  else if ((bus.op == ALU_DIV) && (bus.operand_b != 64'd0))
                     r_state <= S_DIV;
                  else
                     r_state <= S_FINISH;
               end
            end
            S_MUL: begin
               r_prod   <= w_prod_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= w_mul_last ? 7'd0 : r_cnt + 7'd1;
               if (w_mul_last)
                  r_state <= S_DIV;
            end
            S_DIV: begin
               r_cnt <= r_cnt + 7'd1;
               if (w_div_last)
                  r_state <= S_FINISH;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_sum     = (r_op == ALU_SUB) ? ({r_a[63], r_a} - {r_b[63], r_b})
                                        : ({r_a[63], r_a} + {r_b[63], r_b});
   assign w_q_hi_nz = |w_quot[127:64];

   // Signed result and overflow from either the 65-bit sum or the quotient magnitude
   always_comb begin
      w_res = 64'd0;
      w_ovf = 1'b0;
      if (r_dz) begin
         w_res = 64'd0;
         w_ovf = 1'b0;
      end else if ((r_op == ALU_ADD) || (r_op == ALU_SUB)) begin
         w_ovf = w_sum[64] ^ w_sum[63];
         w_res = w_sum[63:0];
`ifdef ALU_SATURATE_EN
         if (w_ovf)
            w_res = w_sum[64] ? S64_MIN : S64_MAX;
`endif
      end else begin
         // A negative result may reach magnitude 2^63; a positive one stops at 2^63-1
         w_ovf = w_q_hi_nz | (r_neg ? (w_quot[63:0] > S64_MIN) : w_quot[63]);
         w_res = r_neg ? (~w_quot[63:0] + 64'd1) : w_quot[63:0];
`ifdef ALU_SATURATE_EN
         if (w_ovf)
            w_res = r_neg ? S64_MIN : S64_MAX;
`endif
      end
   end

   // Registered outputs: result and flags hold until the next done, clear or reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_done   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_dz_out <= 1'b0;
      end else if (bus.clear) begin
         r_done   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_dz_out <= 1'b0;
      end else if (r_state == S_FINISH) begin
         r_done   <= 1'b1;
         r_result <= w_res;
         r_ovf    <= w_ovf;
         r_dz_out <= r_dz;
      end else begin
         r_done <= 1'b0;
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
   assign bus.result   = r_result;
   assign bus.overflow = r_ovf;
   assign bus.div_zero = r_dz_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: latencies, results, flags, clear, reset.
// Latency: n/a.
// Backpressure: exercises start-while-busy and clear abort.
module tb_alu_sequencer;
   import calc_pkg::*;

   localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

`ifdef ALU_SATURATE_EN
   localparam logic [63:0] EXP_ADD_OVF = MAXV;
   localparam logic [63:0] EXP_MUL_OVF = MAXV;
`else
   localparam logic [63:0] EXP_ADD_OVF = 64'h8000_0000_0000_0063;   // -2^63 + 99
   localparam logic [63:0] EXP_MUL_OVF = 64'hFFFF_FFFF_FFFF_FFFE;   // (2^64 - 2) mod 2^64
`endif

   logic clock = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;
   int   n_done;

   alu_sequencer_if bus();

   alu_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag,
                  $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request for one edge (edge k); returns just after edge k
   task automatic launch(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   // Edges until done, bounded; 0 means the bound expired
   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 1; i <= 400; i++) begin
         tick();
         if (bus.done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res,
                      input logic exp_ovf, input logic exp_dz);
      int l;
      launch(op, a, b);
      check({tag, ".busy_rise"}, 64'(bus.busy), 64'd1);
      wait_done(l);
      check({tag, ".latency"}, 64'(l), 64'(exp_lat));
      check({tag, ".result"}, bus.result, exp_res);
      check({tag, ".overflow"}, 64'(bus.overflow), 64'(exp_ovf));
      check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
      check({tag, ".busy_fall"}, 64'(bus.busy), 64'd0);
      tick();
      check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.clear     = 1'b0;
      bus.op        = 2'd0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      reset_n       = 1'b0;
      #12;
      check("rst.busy",     64'(bus.busy),     64'd0);
      check("rst.done",     64'(bus.done),     64'd0);
      check("rst.result",   bus.result,        64'd0);
      check("rst.overflow", 64'(bus.overflow), 64'd0);
      check("rst.div_zero", 64'(bus.div_zero), 64'd0);
      reset_n = 1'b1;
      tick();

      //   tag        op       a             b             lat  result              ovf   dz
      run("mul_pos",  ALU_MUL, 64'd150,      64'd200,      193, 64'd300,            1'b0, 1'b0);
      run("mul_neg",  ALU_MUL, -64'sd150,    64'd200,      193, -64'sd300,          1'b0, 1'b0);
      run("mul_ovf",  ALU_MUL, MAXV,         64'd200,      193, EXP_MUL_OVF,        1'b1, 1'b0);
      run("div_third",ALU_DIV, 64'd100,      64'd300,      129, 64'd33,             1'b0, 1'b0);
      run("div_neg",  ALU_DIV, -64'sd700,    64'd200,      129, -64'sd350,          1'b0, 1'b0);
      run("div_min",  ALU_DIV, MINV,         64'd100,      129, MINV,               1'b0, 1'b0);
      run("div_zero", ALU_DIV, 64'd500,      64'd0,        1,   64'd0,              1'b0, 1'b1);
      run("add_ovf",  ALU_ADD, MAXV,         64'd100,      1,   EXP_ADD_OVF,        1'b1, 1'b0);
      run("sub_neg",  ALU_SUB, -64'sd5,      64'd3,        1,   -64'sd8,            1'b0, 1'b0);

      // Abort a multiply part way through
      launch(ALU_MUL, 64'd150, 64'd200);
      repeat (50) tick();
      check("clr.busy_before", 64'(bus.busy), 64'd1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clr.busy",     64'(bus.busy),     64'd0);
      check("clr.result",   bus.result,        64'd0);
      check("clr.overflow", 64'(bus.overflow), 64'd0);
      check("clr.div_zero", 64'(bus.div_zero), 64'd0);
      n_done = 0;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (bus.done) n_done++;
      end
      check("clr.no_done", 64'(n_done), 64'd0);
      run("add_after_clr", ALU_ADD, 64'd100, 64'd200, 1, 64'd300, 1'b0, 1'b0);

      // A second start while busy is dropped; the first divide completes
      launch(ALU_DIV, 64'd1000, 64'd400);
      repeat (9) tick();
      bus.op        = ALU_MUL;
      bus.operand_a = 64'd7;
      bus.operand_b = 64'd9;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      wait_done(lat);
      check("restart.latency", 64'(lat), 64'd119);
      check("restart.result",  bus.result, 64'd250);
      tick();
      n_done = 0;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (bus.done) n_done++;
      end
      check("restart.no_second", 64'(n_done), 64'd0);

      // Asynchronous reset in the middle of a divide
      launch(ALU_DIV, 64'd100, 64'd300);
      repeat (20) tick();
      check("arst.busy_before", 64'(bus.busy), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst.busy",     64'(bus.busy),     64'd0);
      check("arst.done",     64'(bus.done),     64'd0);
      check("arst.result",   bus.result,        64'd0);
      check("arst.overflow", 64'(bus.overflow), 64'd0);
      check("arst.div_zero", 64'(bus.div_zero), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      run("add_after_rst", ALU_ADD, 64'd1, 64'd2, 1, 64'd3, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle arithmetic sequencer that executes one two-operand fixed-point calculator operation at a time (add, subtract, multiply, divide) under a start/busy/done handshake. It sits between the keypad/state controller and the result register, and replaces single-cycle wide multiply and divide with iterative shift-add and restoring-division loops. Operands and result are signed 64-bit values scaled by 10^FRAC_DIGITS.

## Interface
- FRAC_DIGITS, 2, number of decimal fraction digits; SCALE = 10^FRAC_DIGITS (100 by default)
- clock  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- clear  in  1  synchronous abort; has priority over start
- op  in  2  0 add, 1 sub, 2 mul, 3 div
- operand_a  in  64  signed first operand
- operand_b  in  64  signed second operand
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result and flags valid
- result  out  64  signed result, held until the next done, clear or reset
- overflow  out  1  result not representable in 64 bits; valid with done
- div_zero  out  1  divide with operand_b == 0; valid with done

## Operation
- States: IDLE, MUL, DIV, FINISH.
- IDLE + start:
  - Latch op, the sign of the result (sign_a XOR sign_b for mul/div) and the magnitudes |a| and |b|.
  - add/sub → FINISH.
  - mul → MUL.
  - div with b == 0 → FINISH with div_zero set.
  - div otherwise → DIV, with dividend = |a|·SCALE (128-bit, constant multiply in the accept cycle) and divisor = |b|.
- MUL: 64 iterations of shift-add producing a 128-bit |a|·|b|, then → DIV with dividend = product and divisor = SCALE.
- DIV: 128 iterations of restoring division (128-bit dividend, 64-bit divisor); quotient truncates toward zero; then → FINISH.
- FINISH:
  - Form the signed result: add/sub in 65 bits; mul/div negate the magnitude when the result sign is negative.
  - Register result, flags and done=1, then → IDLE.
- Overflow:
  - add/sub: signed 64-bit overflow.
  - mul/div: quotient magnitude > 2^63−1 for a positive result, or > 2^63 for a negative result.
- Divide by zero: result = 0, overflow = 0, div_zero = 1.
- start while busy: ignored, including during the FINISH cycle.
- clear in any state: → IDLE on the next edge; result = 0; flags = 0; no done pulse.
- reset_n low: immediately IDLE; busy, done, result, overflow and div_zero all 0.

## Timing
- All latencies count rising edges after the edge that samples start (edge k).
- add/sub and div-by-zero: done and result at edge k+1.
- div: done at edge k+129.
- mul: done at edge k+193.
- busy: rises at edge k; falls at the done edge.
- done: high for exactly one cycle. A new start may be sampled on the cycle after done.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ALU_SATURATE_EN defined: on overflow, result clamps to 2^63−1 (positive) or −2^63 (negative).
- ALU_SATURATE_EN undefined: on overflow, result is the low 64 bits of the two's-complement true result.
- overflow flag asserts in both builds.

## Structure
- Shared package calc_pkg holds:
  - alu_op_t enum: ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, encoded 0–3 to match the controller's operation code.
  - FRAC_DIGITS and SCALE constants.
  - seq_state_t enum.
- Sub-module seq_divider: 128/64 restoring divider with load/step/quotient interface. It is reused for both the SCALE division after multiply and for divide.
- Multiply loop and sign/overflow logic live in alu_sequencer.

## Test plan
- mul 150 × 200 (1.50 × 2.00) → done at edge k+193, result 300, overflow 0.
- div 100 / 300 (1.00 / 3.00) → done at edge k+129, result 33; div −700 / 200 → result −350.
- div 500 / 0 → done at edge k+1, result 0, div_zero 1, busy high for exactly one cycle.
- add (2^63−1) + 100 → overflow 1; result 2^63−1 with ALU_SATURATE_EN, −2^63+99 without.
- Start mul, assert clear at edge k+50 → busy 0 at edge k+51, no done, result 0. A following add 100 + 200 → result 300 at its edge k+1.
- Start div, pulse start with new operands at edge k+10 → second start ignored, first result returned. Drop reset_n mid-DIV → all outputs 0 asynchronously.
